// File: rtl/axis_data_unpadding.sv
// Receive-side unpadder: strips all-zero frames from AXI-Stream packets, moves
// tlast onto the last non-zero frame, and reports per-packet frame counts.
`timescale 1ns/1ps
module axis_data_unpadding #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  output logic              m_axis_hsked,
  output logic [CNT_W-1:0]  iFrameNum,
  output logic [CNT_W-1:0]  emptyPktCnt
);

  // Handshakes: a beat transfers on a rising edge where valid && ready.
  // Once m_axis_tvalid is raised, data/last are held until that transfer.

  typedef enum logic {FILL = 1'b0, CLOSE = 1'b1} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              z;
  logic              s_hs;

  assign z             = (s_axis_tdata == '0);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_axis_hsked  = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = hold_data;

  // Ready is built from hold/state, tdata and downstream ready only, so there
  // is no combinational path from s_axis_tvalid back to s_axis_tready.
  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      FILL: begin
        s_axis_tready = !hold_valid || m_axis_tready || (z && !s_axis_tlast);
        if (s_axis_tvalid && hold_valid && (!z || s_axis_tlast)) begin
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = z;
        end
      end
      CLOSE: begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
      end
      default: begin
        s_axis_tready = 1'b1;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (s_hs && !z && s_axis_tlast) next_state = CLOSE;
      CLOSE:   if (m_axis_hsked) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state       <= FILL;
      hold_data   <= '0;
      hold_valid  <= 1'b0;
      pkt_cnt     <= '0;
      iFrameNum   <= '0;
      emptyPktCnt <= '0;
    end else begin
      state <= next_state;
      if (state == FILL && s_hs) begin
        if (!z) begin
          hold_data  <= s_axis_tdata;
          hold_valid <= 1'b1;
        end else if (s_axis_tlast) begin
          if (hold_valid) begin
            hold_valid <= 1'b0;
          end else begin
            emptyPktCnt <= emptyPktCnt + 1'b1;
            iFrameNum   <= '0;
          end
        end
      end else if (state == CLOSE && m_axis_hsked) begin
        hold_valid <= 1'b0;
      end
      // Frame count of the packet is published on the tlast transfer.
      if (m_axis_hsked) begin
        if (m_axis_tlast) begin
          iFrameNum <= pkt_cnt + 1'b1;
          pkt_cnt   <= '0;
        end else begin
          pkt_cnt <= pkt_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_data_unpadding.sv
// Bench for axis_data_unpadding: directed packets from the test plan followed
// by random packets, compared against a packet-level reference model.
`timescale 1ns/1ps
module tb_axis_data_unpadding;
  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_hsked;
  logic [CW-1:0] ifn;
  logic [CW-1:0] empty_cnt;

  axis_data_unpadding #(.DATA_W(DW), .CNT_W(CW)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_hsked  (m_hsked),
    .iFrameNum     (ifn),
    .emptyPktCnt   (empty_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int bp_mode = 0;     // 0: always ready, 1: random, 2: pattern 1,0,0,1
  int bp_idx = 0;
  bit gap_en = 0;

  logic [DW-1:0] pkt_q[$];
  logic [DW:0]   exp_q[$];
  int            exp_empty = 0;

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Downstream ready generator
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom_range(0, 3) != 0);
        default: begin
          m_tready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
          bp_idx++;
        end
      endcase
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic       prev_stall;
    logic [DW:0] prev_beat;
    logic [DW:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("hsked", {{DW{1'b0}}, m_hsked}, {{DW{1'b0}}, m_tvalid && m_tready});
        if (prev_stall) begin
          check("valid_held", {{DW{1'b0}}, m_tvalid}, {{DW{1'b0}}, 1'b1});
          if (m_tvalid) check("beat_stable", {m_tlast, m_tdata}, prev_beat);
        end
        prev_stall = 1'b0;
        if (m_tvalid) begin
          if (!m_tready) begin
            prev_stall = 1'b1;
            prev_beat  = {m_tlast, m_tdata};
            if (s_tvalid) check("s_ready_stall", {{DW{1'b0}}, s_tready}, '0);
          end else if (exp_q.size() == 0) begin
            check("unexpected_beat", {m_tlast, m_tdata}, '1);
          end else begin
            e = exp_q.pop_front();
            check("beat", {m_tlast, m_tdata}, e);
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [DW-1:0] d, input logic l);
    int n;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_tready) break;
    end
    if (n == 200) check("s_ready_timeout", '0, '1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 500; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check("drain_empty", exp_q.size(), 0);
    #1;
  endtask

  // Packet-level model: output is the non-zero frames, tlast on the last.
  task automatic run_pkt();
    int nz;
    int k;
    nz = 0;
    k  = 0;
    foreach (pkt_q[i]) if (pkt_q[i] != '0) nz++;
    foreach (pkt_q[i]) begin
      if (pkt_q[i] != '0) begin
        k++;
        exp_q.push_back({(k == nz), pkt_q[i]});
      end
    end
    if (nz == 0) exp_empty++;
    foreach (pkt_q[i]) send_frame(pkt_q[i], (i == pkt_q.size() - 1));
    drain();
    check("iFrameNum", ifn, nz);
    check("emptyPktCnt", empty_cnt, exp_empty);
    pkt_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 1);
    check("rst_hsked", m_hsked, 0);
    check("rst_iFrameNum", ifn, 0);
    check("rst_emptyPktCnt", empty_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // A: trailing padding
    pkt_q = '{64'hA1, 64'hA2, 64'hA3, 64'h0, 64'h0};
    run_pkt();
    // B: no padding, tlast on a non-zero frame
    pkt_q = '{64'hB1, 64'hB2};
    run_pkt();
    // all-zero packet then single-frame packet
    pkt_q = '{64'h0, 64'h0, 64'h0, 64'h0};
    run_pkt();
    pkt_q = '{64'hC1};
    run_pkt();
    // interior zero
    pkt_q = '{64'hC1, 64'h0, 64'hC2, 64'h0};
    run_pkt();
    // backpressure pattern
    bp_mode = 2;
    bp_idx  = 0;
    pkt_q = '{64'hD1, 64'hD2, 64'hD3, 64'hD4, 64'h0};
    run_pkt();
    bp_mode = 0;
    @(posedge clk);
    #1;

    // reset mid-packet: E1 leaves when E2 arrives, E2 is discarded
    exp_q.push_back({1'b0, 64'hE1});
    send_frame(64'hE1, 1'b0);
    send_frame(64'hE2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_empty = 0;
    check("mid_rst_q", exp_q.size(), 0);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_s_tready", s_tready, 1);
    check("mid_rst_iFrameNum", ifn, 0);
    check("mid_rst_emptyPktCnt", empty_cnt, 0);
    pkt_q = '{64'hF1};
    run_pkt();

    // random packets with random backpressure and input gaps
    bp_mode = 1;
    gap_en  = 1;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) pkt_q.push_back('0);
        else pkt_q.push_back({$urandom, $urandom | 32'h1});
      end
      run_pkt();
    end

    check("final_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
